// File: rtl/clock_setting_ctrl.sv
// Time-setting controller: mode FSM (IDLE -> SET_H -> SET_M -> commit) sitting
// between the timekeeper and the seven-segment driver, with field blink and idle abort.
module clock_setting_ctrl #(
    parameter int unsigned HOURS_MAX      = 24,
    parameter int unsigned MINUTES_MAX    = 60,
    parameter int unsigned BLINK_HALF     = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
    parameter int unsigned HW             = $clog2(HOURS_MAX),
    parameter int unsigned MW             = $clog2(MINUTES_MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [HW-1:0] hours,
    input  logic [MW-1:0] minutes,
    input  logic          mode_btn,
    input  logic          inc_btn,
    input  logic          dec_btn,
    output logic [HW-1:0] disp_hours,
    output logic [MW-1:0] disp_minutes,
    output logic          blank_hours,
    output logic          blank_minutes,
    output logic          setting_active,
    output logic          load,
    output logic [HW-1:0] load_hours,
    output logic [MW-1:0] load_minutes
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned BW = $clog2(BLINK_HALF) + 1;

    typedef enum logic [1:0] {IDLE, SET_H, SET_M} state_t;

    state_t        state, state_nx;
    logic [HW-1:0] edit_h, edit_h_nx, load_h_nx, disp_h_nx;
    logic [MW-1:0] edit_m, edit_m_nx, load_m_nx, disp_m_nx;
    logic [BW-1:0] bcnt, bcnt_nx;
    logic [TW-1:0] tcnt, tcnt_nx;
    logic          phase, phase_nx, load_nx;
    logic          blank_h_nx, blank_m_nx, active_nx, timeout;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        timeout  = (tcnt == TW'(TIMEOUT_CYCLES - 1));
        case (state)
            IDLE:    if (mode_btn) state_nx = SET_H;
            SET_H:   if (mode_btn) state_nx = SET_M; else if (timeout) state_nx = IDLE;
            SET_M:   if (mode_btn) state_nx = IDLE;  else if (timeout) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Edit, blink and timeout datapath; mode outranks inc/dec in the same cycle.
    always_comb begin
        edit_h_nx = edit_h;
        edit_m_nx = edit_m;
        bcnt_nx   = bcnt;
        phase_nx  = phase;
        tcnt_nx   = tcnt;
        load_nx   = 1'b0;
        load_h_nx = load_hours;
        load_m_nx = load_minutes;
        if (state == IDLE) begin
            if (mode_btn) begin
                edit_h_nx = hours;
                edit_m_nx = minutes;
            end
        end else if (mode_btn) begin
            tcnt_nx  = '0;
            bcnt_nx  = '0;
            phase_nx = 1'b0;
            if (state == SET_M) begin
                load_nx   = 1'b1;
                load_h_nx = edit_h;
                load_m_nx = edit_m;
            end
        end else if (inc_btn || dec_btn) begin
            tcnt_nx  = '0;
            bcnt_nx  = '0;
            phase_nx = 1'b0;
            if (state == SET_H) begin
                if (inc_btn && !dec_btn)
                    edit_h_nx = (edit_h == HW'(HOURS_MAX - 1)) ? '0 : edit_h + 1'b1;
                else if (dec_btn && !inc_btn)
                    edit_h_nx = (edit_h == '0) ? HW'(HOURS_MAX - 1) : edit_h - 1'b1;
            end else begin
                if (inc_btn && !dec_btn)
                    edit_m_nx = (edit_m == MW'(MINUTES_MAX - 1)) ? '0 : edit_m + 1'b1;
                else if (dec_btn && !inc_btn)
                    edit_m_nx = (edit_m == '0) ? MW'(MINUTES_MAX - 1) : edit_m - 1'b1;
            end
        end else begin
            tcnt_nx = tcnt + 1'b1;
            if (bcnt == BW'(BLINK_HALF - 1)) begin
                bcnt_nx  = '0;
                phase_nx = ~phase;
            end else begin
                bcnt_nx = bcnt + 1'b1;
            end
        end
        if (state_nx == IDLE) begin
            bcnt_nx  = '0;
            phase_nx = 1'b0;
            tcnt_nx  = '0;
        end
    end

    // Blank and active flags follow the next state so they line up with the phase they show.
    always_comb begin
        disp_h_nx  = (state == IDLE) ? hours   : edit_h;
        disp_m_nx  = (state == IDLE) ? minutes : edit_m;
        blank_h_nx = (state_nx == SET_H) && phase_nx;
        blank_m_nx = (state_nx == SET_M) && phase_nx;
        active_nx  = (state_nx != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edit_h         <= '0;
            edit_m         <= '0;
            bcnt           <= '0;
            phase          <= 1'b0;
            tcnt           <= '0;
            disp_hours     <= '0;
            disp_minutes   <= '0;
            blank_hours    <= 1'b0;
            blank_minutes  <= 1'b0;
            setting_active <= 1'b0;
            load           <= 1'b0;
            load_hours     <= '0;
            load_minutes   <= '0;
        end else begin
            edit_h         <= edit_h_nx;
            edit_m         <= edit_m_nx;
            bcnt           <= bcnt_nx;
            phase          <= phase_nx;
            tcnt           <= tcnt_nx;
            disp_hours     <= disp_h_nx;
            disp_minutes   <= disp_m_nx;
            blank_hours    <= blank_h_nx;
            blank_minutes  <= blank_m_nx;
            setting_active <= active_nx;
            load           <= load_nx;
            load_hours     <= load_h_nx;
            load_minutes   <= load_m_nx;
        end
    end

endmodule
